ads5296_ramp_checker: RTL and testbench
=======================================

# ads5296_ramp_checker

Per-channel ramp test-pattern checker for the ADS5296 receive path.
- Sits directly downstream of the ADS5296 deserialiser interface and consumes its parallel `dout` bus on the `sclk` domain.
- While the ADC runs its digital ramp test pattern, each 10-bit channel is compared against a locally predicted value. The block reports per-channel lock and saturating error counts.
- Software uses the results to sweep IDELAY taps and find the data-eye centre before switching the ADC to normal data.

## Interface

Parameters:
- `G_NUM_UNITS`, 4: ADS5296 chips; channel count N = 4*G_NUM_UNITS.
- `G_STEP`, 1: ramp increment per sample, modulo 1024.
- `G_LOCK_CNT`, 16: consecutive matches needed to enter LOCKED (range 2..255).
- `G_LOSE_CNT`, 4: consecutive mismatches that drop LOCKED back to SEEK (range 1..255).

Ports:
- `sclk` in 1: sample clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 10*N: deserialised samples; channel c occupies bits [10c+9:10c]; one new sample per `sclk`.
- `arm` in 1: level; 1 = checking enabled, 0 = all channels held in IDLE.
- `clear` in 1: single-cycle pulse; zeroes all error counters and the sample counter.
- `chan_sel` in 8: channel index for the `err_cnt` readout; values ≥ N read 0.
- `locked` out N: per-channel LOCKED flag.
- `err_cnt` out 16: saturating error count of the selected channel.
- `sample_cnt` out 32: samples examined since `arm` rose or since `clear`; wraps at 2^32.
- `all_locked` out 1: AND of all `locked` bits.

## Operation

- Stage 0 registers `din` (`din_r`). Stage 1 holds the per-channel state, predictor `exp[9:0]` and counters.
- Per-channel states:
  - IDLE: entered on reset or when `arm`=0. `exp` is 0 and run counters are 0.
  - SEEK: entered on `arm` rising, or from LOCKED after loss of lock.
    - Each cycle `exp` <= `din_r`+G_STEP (mod 1024).
    - If `din_r` == `exp`, `match_run` increments; otherwise `match_run` <= 0.
    - The first sample after entering SEEK is a seed. It is never counted as a match.
    - When `match_run` reaches G_LOCK_CNT, go to LOCKED and clear `miss_run`.
  - LOCKED:
    - On a match, `exp` <= `exp`+G_STEP and `miss_run` <= 0.
    - On a mismatch, `err_cnt_c` increments (saturating at 0xFFFF), `miss_run` increments, and `exp` reseeds to `din_r`+G_STEP.
    - When `miss_run` reaches G_LOSE_CNT, go to SEEK with `match_run` = 0.
- Counters:
  - Errors are counted only in LOCKED. SEEK mismatches are not errors.
  - Wrap from 1023 to 0 (with G_STEP=1) is a match.
  - `sample_cnt` increments on every cycle while `arm`=1.
- Simultaneous events:
  - `clear` together with an error: the counter ends at 0 (clear wins).
  - `arm` falling together with any event: the channel goes to IDLE, and counters keep their values.
  - `arm` rising: all channels enter SEEK together; `sample_cnt` <= 0.
- Reset values: `locked` = 0, `all_locked` = 0, `err_cnt` = 0, `sample_cnt` = 0, every channel in IDLE.
- Asserting `rst_n` mid-operation returns everything to these values immediately, with no glitch dependence on `sclk`.

## Timing

- `din` to the internal compare: 1 `sclk` (the `din_r` register).
- The state/counter update is registered, so the outputs reflect a given sample 2 cycles after `din` presents it.
- With a clean ramp, `locked[c]` rises on edge G_LOCK_CNT+3 after `arm` rises. That is 1 cycle for the `arm` register, 1 seed, G_LOCK_CNT matches and 1 output register.
- `err_cnt` is a registered mux of `chan_sel`: 1 cycle after `chan_sel` changes.
- `all_locked` is registered from the `locked` bits: 1 further cycle.
- `clear` takes effect on the following edge.
- `chan_sel`, `arm` and `clear` are synchronous to `sclk`. A CDC from the wishbone domain is done upstream.

## Structure

- Package `ads5296_pkg`:
  - constant `ADS_SAMPLE_W` = 10;
  - enum `ramp_state_t` {IDLE, SEEK, LOCKED};
  - constant `ERR_CNT_W` = 16.
- Sub-module `ads5296_ramp_chan`: one channel's state machine, predictor and counters. It is generate-instantiated N times.
- The top level holds `din_r`, `sample_cnt`, the readout mux and the `all_locked` reduction.

## Test plan

- **Clean ramp.** G_NUM_UNITS=1, G_LOCK_CNT=16. Drive all 4 channels with ramps from 0 at different offsets, then arm. Required: `locked`=4'hF at cycle 19 after `arm`; `err_cnt`=0 on every channel through 2000 samples, including the 1023→0 wrap; `sample_cnt`=2000.
- **Single glitch.** Once locked, ch2 gets one sample XOR 0x004. Required: ch2 `err_cnt`=2 (the glitch plus the reseed-recovery sample), `locked[2]` stays 1, other channels stay at 0.
- **Lock loss.** Feed ch1 constant 0x155 for 4 cycles while locked. Required: `locked[1]` falls 2 cycles after the 4th bad sample, and `err_cnt`=4. The ramp then resumes and ch1 relocks after 17 samples.
- **Saturation and clear.** Feed ch0 random data for 70000 cycles with G_LOSE_CNT=255 after lock. Required: `err_cnt` holds at 0xFFFF. A `clear` pulse coincident with a mismatch leaves 0.
- **Disarm and reset.** Drop `arm` mid-lock. Required: `locked`=0 next cycle while counts persist. Asserting `rst_n`=0 asynchronously between edges must zero all outputs immediately.
- **Readout.** Set `chan_sel`=9 with N=4. Required: `err_cnt`=0 after 1 cycle.

Source files
------------

// File: rtl/ads5296_pkg.sv
// ---------------------------------------------------------------------------
// ads5296_pkg
// Shared types and constants for the ADS5296 ramp test-pattern checker.
//   ADS_SAMPLE_W : width of one ADC channel sample
//   ERR_CNT_W    : width of each saturating per-channel error counter
//   ramp_state_t : per-channel checker state (IDLE / SEEK / LOCKED)
//   rampNext()   : next ramp value, modulo 2^ADS_SAMPLE_W
// ---------------------------------------------------------------------------
package ads5296_pkg;

    localparam int ADS_SAMPLE_W = 10;
    localparam int ERR_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } ramp_state_t;

    // The ramp wraps naturally because the sum is truncated to the sample width.
    function automatic logic [ADS_SAMPLE_W-1:0] rampNext(
        input logic [ADS_SAMPLE_W-1:0] value,
        input int unsigned             step
    );
        return value + step[ADS_SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/ads5296_ramp_chan.sv
// ---------------------------------------------------------------------------
// ads5296_ramp_chan
// One channel of the ramp checker: state machine, ramp predictor, run-length
// counters and a saturating error counter.
// Ports:
//   sclk, rst_n : sample clock, asynchronous active-low reset
//   i_arm       : level, 0 forces the channel into IDLE
//   i_clear     : pulse, zeroes the error counter
//   i_sample    : registered input sample for this channel
//   o_locked    : registered LOCKED flag
//   o_errCnt    : saturating count of mismatches seen while LOCKED
// ---------------------------------------------------------------------------
module ads5296_ramp_chan
    import ads5296_pkg::*;
#(
    parameter int G_STEP     = 1,
    parameter int G_LOCK_CNT = 16,
    parameter int G_LOSE_CNT = 4
) (
    input  logic                    sclk,
    input  logic                    rst_n,
    input  logic                    i_arm,
    input  logic                    i_clear,
    input  logic [ADS_SAMPLE_W-1:0] i_sample,
    output logic                    o_locked,
    output logic [ERR_CNT_W-1:0]    o_errCnt
);

    localparam logic [7:0] LOCK_CNT_V = 8'(G_LOCK_CNT);
    localparam logic [7:0] LOSE_CNT_V = 8'(G_LOSE_CNT);

    ramp_state_t             r_state;
    logic                    r_seed;
    logic [ADS_SAMPLE_W-1:0] r_exp;
    logic [7:0]              r_matchRun;
    logic [7:0]              r_missRun;
    logic [ERR_CNT_W-1:0]    r_errCnt;
    logic                    r_locked;

    ramp_state_t             w_nextState;
    logic                    w_nextSeed;
    logic [ADS_SAMPLE_W-1:0] w_nextExp;
    logic [7:0]              w_nextMatch;
    logic [7:0]              w_nextMiss;
    logic                    w_errHit;
    logic                    w_isMatch;

    // Next-state logic. Dropping arm overrides everything and parks the
    // channel in IDLE without touching the error count. The sample that
    // follows any entry into SEEK only seeds the predictor, so a stale
    // prediction can never contribute a spurious match.
    always_comb begin
        w_nextState = r_state;
        w_nextSeed  = r_seed;
        w_nextExp   = r_exp;
        w_nextMatch = r_matchRun;
        w_nextMiss  = r_missRun;
        w_errHit    = 1'b0;
        w_isMatch   = (i_sample == r_exp);

        if (!i_arm) begin
            w_nextState = IDLE;
            w_nextSeed  = 1'b0;
            w_nextExp   = '0;
            w_nextMatch = '0;
            w_nextMiss  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextState = SEEK;
                    w_nextSeed  = 1'b1;
                end
                SEEK: begin
                    w_nextExp  = rampNext(i_sample, G_STEP);
                    w_nextMiss = '0;
                    if (r_seed) begin
                        w_nextSeed  = 1'b0;
                        w_nextMatch = '0;
                    end else if (w_isMatch) begin
                        w_nextMatch = r_matchRun + 8'd1;
                        if (w_nextMatch == LOCK_CNT_V) begin
                            w_nextState = LOCKED;
                        end
                    end else begin
                        w_nextMatch = '0;
                    end
                end
                LOCKED: begin
                    if (w_isMatch) begin
                        w_nextExp  = rampNext(r_exp, G_STEP);
                        w_nextMiss = '0;
                    end else begin
                        w_errHit   = 1'b1;
                        w_nextMiss = r_missRun + 8'd1;
                        // Reseed so a single bad sample costs at most two errors.
                        w_nextExp  = rampNext(i_sample, G_STEP);
                        if (w_nextMiss == LOSE_CNT_V) begin
                            w_nextState = SEEK;
                            w_nextSeed  = 1'b1;
                            w_nextMatch = '0;
                        end
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // State and counter registers. Clear beats a coincident error so the
    // counter always reads zero right after a clear pulse.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_seed     <= 1'b0;
            r_exp      <= '0;
            r_matchRun <= '0;
            r_missRun  <= '0;
            r_errCnt   <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_seed     <= w_nextSeed;
            r_exp      <= w_nextExp;
            r_matchRun <= w_nextMatch;
            r_missRun  <= w_nextMiss;
            if (i_clear) begin
                r_errCnt <= '0;
            end else if (w_errHit && (r_errCnt != '1)) begin
                r_errCnt <= r_errCnt + 1'b1;
            end
            r_locked <= i_arm && (r_state == LOCKED);
        end
    end

    assign o_locked = r_locked;
    assign o_errCnt = r_errCnt;

endmodule

// File: rtl/ads5296_ramp_checker.sv
// ---------------------------------------------------------------------------
// ads5296_ramp_checker
// Ramp test-pattern checker for all ADS5296 channels on the sclk domain.
// Ports:
//   sclk, rst_n : sample clock, asynchronous active-low reset
//   din         : 10 bits per channel, channel c at [10c+9:10c]
//   arm         : level, enables checking; rising edge restarts all channels
//   clear       : pulse, zeroes error counters and sample_cnt
//   chan_sel    : channel selected for err_cnt (out-of-range reads 0)
//   locked      : per-channel LOCKED flags
//   err_cnt     : registered error count of the selected channel
//   sample_cnt  : samples examined since arm rose or since clear
//   all_locked  : registered AND of all locked bits
// ---------------------------------------------------------------------------
module ads5296_ramp_checker
    import ads5296_pkg::*;
#(
    parameter int G_NUM_UNITS = 4,
    parameter int G_STEP      = 1,
    parameter int G_LOCK_CNT  = 16,
    parameter int G_LOSE_CNT  = 4
) (
    input  logic                                  sclk,
    input  logic                                  rst_n,
    input  logic [4*G_NUM_UNITS*ADS_SAMPLE_W-1:0] din,
    input  logic                                  arm,
    input  logic                                  clear,
    input  logic [7:0]                            chan_sel,
    output logic [4*G_NUM_UNITS-1:0]              locked,
    output logic [ERR_CNT_W-1:0]                  err_cnt,
    output logic [31:0]                           sample_cnt,
    output logic                                  all_locked
);

    localparam int NUM_CH = 4 * G_NUM_UNITS;

    logic [NUM_CH*ADS_SAMPLE_W-1:0] r_din;
    logic                           r_armPrev;
    logic [31:0]                    r_sampleCnt;
    logic [ERR_CNT_W-1:0]           r_errOut;
    logic                           r_allLocked;

    logic [NUM_CH-1:0]              w_locked;
    logic [ERR_CNT_W-1:0]           w_chanErr [NUM_CH];
    logic [ERR_CNT_W-1:0]           w_selErr;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        ads5296_ramp_chan #(
            .G_STEP     (G_STEP),
            .G_LOCK_CNT (G_LOCK_CNT),
            .G_LOSE_CNT (G_LOSE_CNT)
        ) u_chan (
            .sclk     (sclk),
            .rst_n    (rst_n),
            .i_arm    (arm),
            .i_clear  (clear),
            .i_sample (r_din[c*ADS_SAMPLE_W +: ADS_SAMPLE_W]),
            .o_locked (w_locked[c]),
            .o_errCnt (w_chanErr[c])
        );
    end

    // Readout mux; any index beyond the last channel falls through to zero.
    always_comb begin
        w_selErr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (chan_sel == 8'(c)) begin
                w_selErr = w_chanErr[c];
            end
        end
    end

    // Input register, sample counter and registered outputs. The arm edge is
    // detected locally so sample_cnt restarts together with the channels.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_din       <= '0;
            r_armPrev   <= 1'b0;
            r_sampleCnt <= '0;
            r_errOut    <= '0;
            r_allLocked <= 1'b0;
        end else begin
            r_din     <= din;
            r_armPrev <= arm;
            if (clear || (arm && !r_armPrev)) begin
                r_sampleCnt <= '0;
            end else if (arm) begin
                r_sampleCnt <= r_sampleCnt + 32'd1;
            end
            r_errOut    <= w_selErr;
            r_allLocked <= &w_locked;
        end
    end

    assign locked     = w_locked;
    assign err_cnt    = r_errOut;
    assign sample_cnt = r_sampleCnt;
    assign all_locked = r_allLocked;

endmodule

// File: tb/tb_ads5296_ramp_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ads5296_ramp_checker
// Directed bench for the ADS5296 ramp checker. Instance A (lose count 4)
// covers lock timing, glitches, lock loss, readout, disarm and async reset;
// instance B (lose count 255) covers counter saturation and clear priority.
// ---------------------------------------------------------------------------
module tb_ads5296_ramp_checker;

    localparam int NCH = 4;

    logic              sclk = 1'b0;
    logic              rst_n;
    logic [NCH*10-1:0] dinA, dinB;
    logic              armA, armB, clearA, clearB;
    logic [7:0]        selA, selB;
    logic [NCH-1:0]    lockedA, lockedB;
    logic [15:0]       errA, errB;
    logic [31:0]       scntA, scntB;
    logic              allA, allB;

    int          nChecks = 0;
    int          nFails  = 0;
    int          k       = 0;
    int          kb      = 0;
    int          offs [NCH] = '{0, 100, 517, 900};
    logic [9:0]  chanVal [NCH];
    logic        armPrevTb = 1'b0;
    int          expSample = 0;

    typedef struct {
        logic [7:0]  sel;
        logic [15:0] expErr;
    } readVec_t;

    readVec_t readVecs [7];

    always #5 sclk = ~sclk;

    ads5296_ramp_checker #(
        .G_NUM_UNITS (1),
        .G_STEP      (1),
        .G_LOCK_CNT  (16),
        .G_LOSE_CNT  (4)
    ) dutA (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .din        (dinA),
        .arm        (armA),
        .clear      (clearA),
        .chan_sel   (selA),
        .locked     (lockedA),
        .err_cnt    (errA),
        .sample_cnt (scntA),
        .all_locked (allA)
    );

    ads5296_ramp_checker #(
        .G_NUM_UNITS (1),
        .G_STEP      (1),
        .G_LOCK_CNT  (16),
        .G_LOSE_CNT  (255)
    ) dutB (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .din        (dinB),
        .arm        (armB),
        .clear      (clearB),
        .chan_sel   (selB),
        .locked     (lockedB),
        .err_cnt    (errB),
        .sample_cnt (scntB),
        .all_locked (allB)
    );

    function automatic logic [9:0] rampAt(input int c, input int idx);
        return 10'((idx + offs[c]) % 1024);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive instance A's din from chanVal.
    task automatic applyStimulus();
        for (int c = 0; c < NCH; c++) begin
            dinA[c*10 +: 10] = chanVal[c];
        end
    endtask

    // One sclk edge for instance A, keeping the expected sample count.
    task automatic tickA();
        if (clearA || (armA && !armPrevTb)) expSample = 0;
        else if (armA)                      expSample++;
        armPrevTb = armA;
        @(posedge sclk);
        #1;
        k++;
    endtask

    task automatic runRamp(input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NCH; c++) chanVal[c] = rampAt(c, k);
            applyStimulus();
            tickA();
        end
    endtask

    // One sclk edge for instance B with ch0 given explicitly.
    task automatic driveB(input logic [9:0] ch0);
        dinB[9:0] = ch0;
        for (int c = 1; c < NCH; c++) dinB[c*10 +: 10] = rampAt(c, kb);
        @(posedge sclk);
        #1;
        kb++;
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] prevB;
        logic [9:0] v;

        readVecs[0] = '{sel: 8'd0,   expErr: 16'd0};
        readVecs[1] = '{sel: 8'd1,   expErr: 16'd4};
        readVecs[2] = '{sel: 8'd2,   expErr: 16'd2};
        readVecs[3] = '{sel: 8'd3,   expErr: 16'd0};
        readVecs[4] = '{sel: 8'd9,   expErr: 16'd0};
        readVecs[5] = '{sel: 8'd4,   expErr: 16'd0};
        readVecs[6] = '{sel: 8'd255, expErr: 16'd0};

        rst_n  = 1'b0;
        armA   = 1'b0; armB   = 1'b0;
        clearA = 1'b0; clearB = 1'b0;
        selA   = 8'd0; selB   = 8'd0;
        dinA   = '0;   dinB   = '0;

        // Reset state
        runRamp(3);
        checkOutput("reset_locked", 32'(lockedA), 32'h0);
        checkOutput("reset_all_locked", 32'(allA), 32'h0);
        checkOutput("reset_err_cnt", 32'(errA), 32'h0);
        checkOutput("reset_sample_cnt", scntA, 32'h0);
        rst_n = 1'b1;
        runRamp(3);
        checkOutput("idle_locked", 32'(lockedA), 32'h0);

        // Clean ramp: lock lands on edge 19 after arm, all_locked one later
        $display("[TB] clean ramp");
        armA = 1'b1;
        runRamp(18);
        checkOutput("lock_early", 32'(lockedA), 32'h0);
        runRamp(1);
        checkOutput("lock_edge19", 32'(lockedA), 32'hF);
        checkOutput("all_locked_lag", 32'(allA), 32'h0);
        runRamp(1);
        checkOutput("all_locked", 32'(allA), 32'h1);
        runRamp(1981);
        checkOutput("sample_cnt_2000", scntA, 32'd2000);
        for (int c = 0; c < NCH; c++) begin
            selA = 8'(c);
            runRamp(1);
            checkOutput($sformatf("clean_err_ch%0d", c), 32'(errA), 32'h0);
        end

        // Single glitch on ch2
        $display("[TB] single glitch");
        selA = 8'd2;
        for (int c = 0; c < NCH; c++) chanVal[c] = rampAt(c, k);
        chanVal[2] = chanVal[2] ^ 10'h004;
        applyStimulus();
        tickA();
        for (int i = 0; i < 6; i++) begin
            runRamp(1);
            checkOutput("glitch_locked", 32'(lockedA), 32'hF);
        end
        checkOutput("glitch_err", 32'(errA), 32'd2);

        // Lock loss on ch1 with four constant samples
        $display("[TB] lock loss");
        selA = 8'd1;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < NCH; c++) chanVal[c] = rampAt(c, k);
            chanVal[1] = 10'h155;
            applyStimulus();
            tickA();
        end
        runRamp(1);
        checkOutput("loss_hold", 32'(lockedA[1]), 32'h1);
        runRamp(1);
        checkOutput("loss_fall", 32'(lockedA[1]), 32'h0);
        checkOutput("loss_err", 32'(errA), 32'd4);
        runRamp(16);
        checkOutput("relock_early", 32'(lockedA[1]), 32'h0);
        runRamp(1);
        checkOutput("relock", 32'(lockedA[1]), 32'h1);

        // Readout table
        for (int i = 0; i < 7; i++) begin
            selA = readVecs[i].sel;
            runRamp(1);
            checkOutput($sformatf("readout_sel%0d", readVecs[i].sel), 32'(errA),
                        32'(readVecs[i].expErr));
        end

        // Disarm keeps counts
        $display("[TB] disarm and reset");
        selA = 8'd1;
        armA = 1'b0;
        runRamp(1);
        checkOutput("disarm_locked", 32'(lockedA), 32'h0);
        runRamp(1);
        checkOutput("disarm_all_locked", 32'(allA), 32'h0);
        checkOutput("disarm_err_keep", 32'(errA), 32'd4);
        checkOutput("disarm_scnt_keep", scntA, 32'(expSample));
        armA = 1'b1;
        runRamp(19);
        checkOutput("rearm_lock", 32'(lockedA), 32'hF);
        checkOutput("rearm_scnt", scntA, 32'd18);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_locked", 32'(lockedA), 32'h0);
        checkOutput("areset_all_locked", 32'(allA), 32'h0);
        checkOutput("areset_err_cnt", 32'(errA), 32'h0);
        checkOutput("areset_sample_cnt", scntA, 32'h0);
        armA = 1'b0;
        @(posedge sclk);
        #1;
        rst_n     = 1'b1;
        armPrevTb = 1'b0;
        expSample = 0;

        // Saturation on instance B with a match every 100 samples
        $display("[TB] saturation and clear");
        armB = 1'b1;
        for (int i = 0; i < 22; i++) driveB(rampAt(0, kb));
        checkOutput("sat_prelock", 32'(lockedB), 32'hF);
        prevB = rampAt(0, kb - 1);
        selB  = 8'd0;
        for (int i = 0; i < 70050; i++) begin
            if ((i % 100) == 99) begin
                v = prevB + 10'd1;
            end else begin
                v = 10'($urandom);
                if (v == prevB + 10'd1) v = v + 10'd1;
            end
            driveB(v);
            prevB = v;
        end
        checkOutput("sat_hold", 32'(errB), 32'hFFFF);
        checkOutput("sat_locked", 32'(lockedB[0]), 32'h1);

        clearB = 1'b1;
        v = 10'($urandom);
        if (v == prevB + 10'd1) v = v + 10'd1;
        driveB(v);
        prevB  = v;
        clearB = 1'b0;
        v = 10'($urandom);
        if (v == prevB + 10'd1) v = v + 10'd1;
        driveB(v);
        prevB = v;
        checkOutput("clear_wins", 32'(errB), 32'h0);
        checkOutput("clear_scnt", scntB, 32'd1);
        v = 10'($urandom);
        if (v == prevB + 10'd1) v = v + 10'd1;
        driveB(v);
        checkOutput("clear_recount", 32'(errB), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
